// File: rtl/ethernet_tx_arbiter.sv
// ethernet_tx_arbiter
//   Round-robin arbiter that gives one packet producer at a time exclusive use
//   of ethernet_sender's host write port for a whole packet (size write, data
//   writes, send). A grant is released on send, on withdrawal of the owner's
//   request, or when the idle-grant watchdog expires.
// Ports
//   clk_i, reset_n_i            clock, async active-low reset
//   req_i / grant_o             per-requester request, registered one-hot grant
//   req_ready_o                 owner's view of the sender's slot availability
//   req_w*_i, req_send_i        per-requester write port (flattened, N slices)
//   packet_req_i                sender has a free packet slot
//   packet_w*_o, packet_send_o  forwarded write port of the current owner
//   grant_id_o                  index of current/last owner
//   busy_o                      a grant is active
//   timeout_o                   1-cycle pulse, watchdog released a grant
//   protocol_err_o              1-cycle pulse, an illegal strobe was dropped
module ethernet_tx_arbiter #(
   parameter  int num_req_p    = 2,
   parameter  int data_width_p = 32,
   parameter  int eth_mtu_p    = 2048,
   parameter  int timeout_p    = 4096,
   localparam int size_w       = $clog2($clog2(data_width_p/8) + 1),
   localparam int addr_w       = $clog2(eth_mtu_p),
   localparam int psize_w      = $clog2(eth_mtu_p + 1),
   localparam int id_w         = $clog2(num_req_p)
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_req_p-1:0]             req_i,
   output logic [num_req_p-1:0]             grant_o,
   output logic [num_req_p-1:0]             req_ready_o,
   input  logic [num_req_p-1:0]             req_wsize_valid_i,
   input  logic [num_req_p*psize_w-1:0]     req_wsize_i,
   input  logic [num_req_p-1:0]             req_wvalid_i,
   input  logic [num_req_p*addr_w-1:0]      req_waddr_i,
   input  logic [num_req_p*data_width_p-1:0] req_wdata_i,
   input  logic [num_req_p*size_w-1:0]      req_wdata_size_i,
   input  logic [num_req_p-1:0]             req_send_i,
   input  logic                             packet_req_i,
   output logic                             packet_wsize_valid_o,
   output logic [psize_w-1:0]               packet_wsize_o,
   output logic                             packet_wvalid_o,
   output logic [addr_w-1:0]                packet_waddr_o,
   output logic [data_width_p-1:0]          packet_wdata_o,
   output logic [size_w-1:0]                packet_wdata_size_o,
   output logic                             packet_send_o,
   output logic [id_w-1:0]                  grant_id_o,
   output logic                             busy_o,
   output logic                             timeout_o,
   output logic                             protocol_err_o
);

   // One extra bit keeps the counter meaningful when the watchdog is disabled.
   localparam int wdog_w = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
   localparam logic [wdog_w-1:0] wdog_lim = wdog_w'((timeout_p > 0) ? timeout_p - 1 : 0);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e                state_q, state_d;
   logic [num_req_p-1:0]  grant_q, grant_d;
   logic [id_w-1:0]       id_q, id_d;
   logic [id_w-1:0]       last_q, last_d;
   logic [wdog_w-1:0]     wdog_q, wdog_d;
   logic                  timeout_q, timeout_d;
   logic                  err_q, err_d;

   logic [num_req_p-1:0]  any_strobe;
   logic                  own_strobe, fwd_any, found;
   logic [id_w-1:0]       pick;
   int                    idx;

   assign any_strobe  = req_wsize_valid_i | req_wvalid_i | req_send_i;
   assign grant_o     = grant_q;
   assign req_ready_o = grant_q & {num_req_p{packet_req_i}};
   assign grant_id_o  = id_q;
   assign busy_o      = (state_q == GRANT);
   assign timeout_o   = timeout_q;
   assign protocol_err_o = err_q;

   // Data buses follow the current/last owner; only the strobes are qualified.
   assign packet_wsize_o      = req_wsize_i[int'(id_q)*psize_w +: psize_w];
   assign packet_waddr_o      = req_waddr_i[int'(id_q)*addr_w +: addr_w];
   assign packet_wdata_o      = req_wdata_i[int'(id_q)*data_width_p +: data_width_p];
   assign packet_wdata_size_o = req_wdata_size_i[int'(id_q)*size_w +: size_w];

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      id_d      = id_q;
      last_d    = last_q;
      wdog_d    = wdog_q;
      timeout_d = 1'b0;
      err_d     = 1'b0;
      packet_wsize_valid_o = 1'b0;
      packet_wvalid_o      = 1'b0;
      packet_send_o        = 1'b0;
      own_strobe = 1'b0;
      fwd_any    = 1'b0;
      found      = 1'b0;
      pick       = '0;
      idx        = 0;

      // Round-robin scan starting just after the last owner.
      for (int k = 1; k <= num_req_p; k++) begin
         idx = (int'(last_q) + k) % num_req_p;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            pick  = id_w'(idx);
         end
      end

      case (state_q)
         IDLE: begin
            // With no owner every strobe is illegal.
            err_d = |any_strobe;
            if (found && packet_req_i) begin
               state_d       = GRANT;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               id_d          = pick;
               wdog_d        = '0;
            end
         end
         GRANT: begin
            own_strobe = any_strobe[id_q];
            packet_wsize_valid_o = req_wsize_valid_i[id_q] & packet_req_i;
            packet_wvalid_o      = req_wvalid_i[id_q] & packet_req_i;
            packet_send_o        = req_send_i[id_q] & packet_req_i;
            fwd_any = packet_wsize_valid_o | packet_wvalid_o | packet_send_o;
            err_d   = (|(any_strobe & ~grant_q)) | (own_strobe & ~packet_req_i);

            if (fwd_any)
               wdog_d = '0;
            else if (wdog_q != '1)
               wdog_d = wdog_q + 1'b1;

            // Single release per cycle: send > withdrawal > timeout.
            if (packet_send_o || !req_i[id_q]) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = id_q;
            end else if ((timeout_p != 0) && !fwd_any && (wdog_q == wdog_lim)) begin
               state_d   = IDLE;
               grant_d   = '0;
               last_d    = id_q;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         id_q      <= '0;
         last_q    <= id_w'(num_req_p - 1);
         wdog_q    <= '0;
         timeout_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         last_q    <= last_d;
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
      end
   end

endmodule
